// File: rtl/image_rle_decompressor.sv
// Expands 16-bit run-length words into 1-bit pixels, packs them MSB-first and writes bytes from img_base.
// One pixel per cycle; in_ready is high only while waiting for a word, write/done/err outputs are registered.
module image_rle_decompressor #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [PIX_W-1:0]  pixel_total,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, EXPAND, FLUSH, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] byteIdx;
  logic [PIX_W-1:0]  total;
  logic [PIX_W-1:0]  pixCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic [14:0]       runLeft;
  logic              pixVal;
  logic              ovrFlag;

  logic [PIX_W-1:0]  pixNext;
  logic [2:0]        bitNext;
  logic [14:0]       runNext;
  logic [7:0]        shiftNext;
  logic [7:0]        flushByte;

  assign pixNext   = pixCnt + PIX_W'(1);
  assign bitNext   = bitCnt + 3'd1;
  assign runNext   = runLeft - 15'd1;
  assign shiftNext = {shiftReg[6:0], pixVal};
  // Partial byte: the oldest pixel ends up in bit 7, unused low bits are zero.
  assign flushByte = shiftReg << (4'd8 - {1'b0, bitCnt});

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      base     <= '0;
      byteIdx  <= '0;
      total    <= '0;
      pixCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      runLeft  <= '0;
      pixVal   <= 1'b0;
      ovrFlag  <= 1'b0;
      in_ready <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (start) begin
        // Restart from any state; a byte completing in this cycle is dropped.
        base     <= img_base;
        total    <= pixel_total;
        byteIdx  <= '0;
        pixCnt   <= '0;
        bitCnt   <= '0;
        shiftReg <= '0;
        runLeft  <= '0;
        ovrFlag  <= 1'b0;
        done     <= 1'b0;
        err      <= 1'b0;
        if (pixel_total != '0) begin
          state    <= WAIT_WORD;
          in_ready <= 1'b1;
        end else begin
          state    <= DONE;
          in_ready <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b0;
          end
          WAIT_WORD: begin
            if (in_valid && in_data[14:0] != 15'd0) begin
              pixVal   <= in_data[15];
              runLeft  <= in_data[14:0];
              state    <= EXPAND;
              in_ready <= 1'b0;
            end
          end
          EXPAND: begin
            shiftReg <= shiftNext;
            bitCnt   <= bitNext;
            pixCnt   <= pixNext;
            runLeft  <= runNext;
            if (bitNext == 3'd0) begin
              ram_we   <= 1'b1;
              ram_data <= shiftNext;
              ram_addr <= base + byteIdx;
              byteIdx  <= byteIdx + ADDR_W'(1);
            end
            if (pixNext == total) begin
              if (runNext != 15'd0)
                ovrFlag <= 1'b1;
              state <= (bitNext != 3'd0) ? FLUSH : DONE;
            end else if (runNext == 15'd0) begin
              state    <= WAIT_WORD;
              in_ready <= 1'b1;
            end
          end
          FLUSH: begin
            ram_we   <= 1'b1;
            ram_data <= flushByte;
            ram_addr <= base + byteIdx;
            byteIdx  <= byteIdx + ADDR_W'(1);
            state    <= DONE;
          end
          DONE: begin
            // One cycle behind state entry so done follows the last write strobe.
            done <= 1'b1;
            err  <= ovrFlag;
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_rle_decompressor.sv
// Bench for image_rle_decompressor: fixed vectors, restart/reset sequences and random images
// checked against a pixel-list model of the run-length format.
module tb_image_rle_decompressor;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] img_base = '0;
  logic [15:0] pixel_total = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        done;
  logic        err;

  image_rle_decompressor #(.PIX_W(16), .ADDR_W(16)) dut (
    .clk(clk), .RST(RST), .start(start), .img_base(img_base), .pixel_total(pixel_total),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_we(ram_we), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCyc = -1;
  int errCyc = -1;
  logic [15:0] wrAddr[$];
  logic [7:0]  wrData[$];
  int          wrCyc[$];
  logic [15:0] curWords[$];
  int          accCyc[$];

  typedef struct packed {
    logic [15:0]      base;
    logic [15:0]      total;
    logic [3:0][15:0] words;
    logic [2:0]       nWords;
    logic [2:0]       gap;
    logic [2:0]       nWr;
    logic [3:0][7:0]  bytes;
    logic             expErr;
  } vec_t;

  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RST && ram_we) begin
      wrAddr.push_back(ram_addr);
      wrData.push_back(ram_data);
      wrCyc.push_back(cyc);
    end
    if (done && doneCyc < 0) doneCyc = cyc;
    if (err && errCyc < 0) errCyc = cyc;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] base, input logic [15:0] total, input int n,
                              input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input int gap, input int nWr,
                              input logic [7:0] b0, input logic [7:0] b1, input logic expErr);
    vec_t v;
    v.base = base; v.total = total; v.nWords = 3'(n); v.gap = 3'(gap); v.nWr = 3'(nWr);
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.bytes[0] = b0; v.bytes[1] = b1; v.bytes[2] = 8'h00; v.bytes[3] = 8'h00;
    v.expErr = expErr;
    return v;
  endfunction

  task automatic clearMon();
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    curWords.delete(); accCyc.delete();
    doneCyc = -1; errCyc = -1;
  endtask

  task automatic startImage(input logic [15:0] base, input logic [15:0] total);
    @(negedge clk);
    start = 1'b1; img_base = base; pixel_total = total;
    @(posedge clk);
    #1;
    start = 1'b0;
    clearMon();
  endtask

  task automatic sendWord(input logic [15:0] w, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = w;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("word accepted", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      @(posedge clk);
      #1;
      curWords.push_back(w);
      accCyc.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, " done reached"}, {63'd0, done}, 64'd1);
  endtask

  // Reference: expand the accepted words into a pixel list, pack bytes, derive write timing.
  task automatic checkModel(input logic [15:0] base, input int total, input string tag);
    logic pix[$];
    int wStart[$];
    int eff[$];
    int p;
    bit ovr;
    int nBytes;
    int lastCyc;
    p = 0; ovr = 0; lastCyc = -1;
    foreach (curWords[i]) begin
      int run;
      int e;
      run = int'(curWords[i][14:0]);
      e = (run < total - p) ? run : total - p;
      wStart.push_back(p);
      eff.push_back(e);
      for (int k = 0; k < e; k++) pix.push_back(curWords[i][15]);
      p += e;
      if (run > e) ovr = 1;
    end
    nBytes = (total + 7) / 8;
    chk({tag, " write count"}, wrAddr.size(), nBytes);
    for (int b = 0; b < nBytes; b++) begin
      logic [7:0] eb;
      int j;
      int wi;
      int ec;
      eb = 8'h00;
      for (int k = 0; k < 8; k++)
        if (8 * b + k < total) eb[7-k] = pix[8*b+k];
      j = (8 * b + 8 < total) ? 8 * b + 8 : total;
      wi = 0;
      foreach (eff[i])
        if (eff[i] > 0 && j > wStart[i] && j <= wStart[i] + eff[i]) wi = i;
      ec = accCyc[wi] + (j - wStart[wi]) + ((j % 8 != 0) ? 1 : 0);
      lastCyc = ec;
      if (b < wrAddr.size())
        chk({tag, " write addr/data/cycle"}, {wrAddr[b], wrData[b], 32'(wrCyc[b])},
            {16'(base + 16'(b)), eb, 32'(ec)});
    end
    chk({tag, " done cycle"}, doneCyc, lastCyc + 1);
    chk({tag, " err"}, {63'd0, err}, {63'd0, ovr});
    chk({tag, " err cycle"}, errCyc, ovr ? doneCyc : -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int acc;
    vecs[0] = mk(16'h0100, 16'd16, 2, 16'h8008, 16'h0008, 16'h0, 16'h0, 0, 2, 8'hFF, 8'h00, 1'b0);
    vecs[1] = mk(16'h0040, 16'd10, 1, 16'h800A, 16'h0, 16'h0, 16'h0, 0, 2, 8'hFF, 8'hC0, 1'b0);
    vecs[2] = mk(16'h0123, 16'd8, 4, 16'h8003, 16'h0000, 16'h0002, 16'h8003, 3, 1, 8'hE7, 8'h00, 1'b0);
    vecs[3] = mk(16'hFFFF, 16'd16, 1, 16'h8010, 16'h0, 16'h0, 16'h0, 1, 2, 8'hFF, 8'hFF, 1'b0);
    vecs[4] = mk(16'h0080, 16'd4, 1, 16'h8006, 16'h0, 16'h0, 16'h0, 0, 1, 8'hF0, 8'h00, 1'b1);

    #1;
    chk("reset outputs", {36'd0, in_ready, ram_we, done, err, ram_addr, ram_data}, 64'd0);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle in_ready/done", {62'd0, in_ready, done}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      startImage(vecs[v].base, vecs[v].total);
      chk("start clears done/err", {62'd0, done, err}, 64'd0);
      for (int w = 0; w < int'(vecs[v].nWords); w++)
        sendWord(vecs[v].words[w], int'(vecs[v].gap));
      waitDone("vector");
      chk("vector write count", wrAddr.size(), int'(vecs[v].nWr));
      for (int b = 0; b < int'(vecs[v].nWr); b++)
        if (b < wrAddr.size())
          chk("vector byte", {wrAddr[b], wrData[b]}, {16'(vecs[v].base + 16'(b)), vecs[v].bytes[b]});
      chk("vector err", {63'd0, err}, {63'd0, vecs[v].expErr});
      checkModel(vecs[v].base, int'(vecs[v].total), "vector model");
    end

    // After the overrun image a new word must be refused and the flags must hold.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h8003;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready) seen++;
    end
    in_valid = 1'b0;
    chk("done state refuses word", seen, 0);
    chk("done state no write", wrAddr.size(), 1);
    chk("done state flags held", {62'd0, done, err}, 64'd3);

    startImage(16'h0700, 16'd0);
    waitDone("zero total");
    chk("zero total writes", wrAddr.size(), 0);
    chk("zero total err/in_ready", {62'd0, err, in_ready}, 64'd0);

    // Asynchronous reset in the middle of a 20-pixel run.
    startImage(16'h0300, 16'd100);
    sendWord(16'h8014, 0);
    acc = accCyc[0];
    while (cyc < acc + 12) @(posedge clk);
    #3;
    chk("pre-reset write seen", wrAddr.size(), 1);
    RST = 1'b0;
    #1;
    chk("async reset outputs", {36'd0, in_ready, ram_we, done, err, ram_addr, ram_data}, 64'd0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset idle", {62'd0, in_ready, done}, 64'd0);
    chk("post-reset no write", wrAddr.size(), 1);

    // Restart at the edge that would complete the second byte of the old image.
    startImage(16'h0500, 16'd40);
    sendWord(16'h8020, 0);
    acc = accCyc[0];
    while (cyc < acc + 15) @(posedge clk);
    #1;
    startImage(16'h0200, 16'd8);
    chk("restart err cleared", {63'd0, err}, 64'd0);
    sendWord(16'h8008, 0);
    waitDone("restart");
    checkModel(16'h0200, 8, "restart");

    for (int t = 0; t < 30; t++) begin
      logic [15:0] base;
      int total;
      int sum;
      base = 16'($urandom);
      total = $urandom_range(1, 60);
      startImage(base, 16'(total));
      sum = 0;
      while (sum < total) begin
        int run;
        run = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
        sendWord({1'($urandom_range(0, 1)), 15'(run)}, $urandom_range(0, 2));
        sum += run;
      end
      waitDone("random");
      checkModel(base, total, "random");
      chk("random in_ready low in done", {63'd0, in_ready}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
